// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the LFSR generator/checker pair; both ends must agree
// on the default polynomial.
package lfsr_checker_pkg;
  localparam int                    LFSR_BITS         = 5;
  localparam logic [LFSR_BITS-1:0]  LFSR_DEFAULT_TAPS = 5'b10100;  // x^5+x^3+1

  typedef enum logic {SEED, LOCKED} chk_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset_i)                  count <= '0;
    else if (clear)               count <= '0;
    else if (inc && count != '1)  count <= count + WIDTH'(1);
  end
endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronizing receive checker for a Fibonacci LFSR bit stream: seeds a
// local LFSR from received bits, then predicts and flags each following bit.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int              BITS         = LFSR_BITS,
  parameter logic [BITS-1:0] DEFAULT_TAPS = LFSR_DEFAULT_TAPS,
  parameter int              LOSS_THRESH  = 3,
  parameter int              COUNT_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic [BITS-1:0]       taps_i,
  input  logic                  load_taps_i,
  input  logic                  clear_i,
  input  logic                  bit_i,
  input  logic                  bit_valid_i,
  output logic                  locked_o,
  output logic                  error_o,
  output logic [COUNT_BITS-1:0] err_count_o
);
  localparam int SEED_W   = $clog2(BITS + 1);
  localparam int CONSEC_W = $clog2(LOSS_THRESH + 1);

  chk_state_e            state_q, state_d;
  logic [BITS-1:0]       taps_q, shift_q, shift_n;
  logic [SEED_W-1:0]     seed_cnt;
  logic [CONSEC_W-1:0]   consec_err;
  logic                  error_q;
  logic                  take_bit, pred, mispredict, seed_full, lose_lock;

  // A tap load in the same cycle swallows the incoming bit.
  assign take_bit   = bit_valid_i & ~load_taps_i;
  assign shift_n    = {shift_q[BITS-2:0], bit_i};
  assign pred       = ^(shift_q & taps_q);
  assign mispredict = take_bit & (state_q == LOCKED) & (bit_i != pred);
  assign seed_full  = (seed_cnt == SEED_W'(BITS - 1));
  assign lose_lock  = mispredict & (consec_err == CONSEC_W'(LOSS_THRESH - 1));

  always_ff @(posedge clk) begin
    if (reset_i) state_q <= SEED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load_taps_i) begin
      state_d = SEED;
    end else if (take_bit) begin
      case (state_q)
        SEED:    if (seed_full && shift_n != '0) state_d = LOCKED;
        LOCKED:  if (lose_lock) state_d = SEED;
        default: state_d = SEED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      taps_q     <= DEFAULT_TAPS;
      shift_q    <= '0;
      seed_cnt   <= '0;
      consec_err <= '0;
      error_q    <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (load_taps_i) begin
        taps_q     <= taps_i;
        seed_cnt   <= '0;
        consec_err <= '0;
      end else if (take_bit) begin
        // Always shift in the received bit, never the prediction.
        shift_q <= shift_n;
        if (state_q == SEED) begin
          seed_cnt <= seed_full ? '0 : seed_cnt + SEED_W'(1);
        end else begin
          error_q <= mispredict;
          if (lose_lock)       consec_err <= '0;
          else if (mispredict) consec_err <= consec_err + CONSEC_W'(1);
          else                 consec_err <= '0;
          if (lose_lock) seed_cnt <= '0;
        end
      end
    end
  end

  sat_counter #(.WIDTH(COUNT_BITS)) u_err_cnt (
    .clk     (clk),
    .reset_i (reset_i),
    .clear   (clear_i & ~load_taps_i),
    .inc     (mispredict),
    .count   (err_count_o)
  );

  assign locked_o = (state_q == LOCKED);
  assign error_o  = error_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: table-driven lock-up plus hand-built
// sequences for errors, lock loss, all-zero seeds, saturation and priorities.
module tb_lfsr_checker;
  logic       clk = 1'b0;
  logic       reset_i, load_taps_i, clear_i, bit_i, bit_valid_i;
  logic [4:0] taps_i;
  logic       locked_o, error_o;
  logic [7:0] err_count_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] gen_state, gen_taps;

  typedef struct {
    logic       valid;
    logic       b;
    logic       exp_locked;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .taps_i      (taps_i),
    .load_taps_i (load_taps_i),
    .clear_i     (clear_i),
    .bit_i       (bit_i),
    .bit_valid_i (bit_valid_i),
    .locked_o    (locked_o),
    .error_o     (error_o),
    .err_count_o (err_count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference generator: same Fibonacci convention as the transmitter.
  task automatic gen_bit(output logic b);
    b         = ^(gen_state & gen_taps);
    gen_state = {gen_state[3:0], b};
  endtask

  task automatic send(input logic b, input logic clr);
    bit_i = b; bit_valid_i = 1'b1; clear_i = clr;
    step();
    bit_valid_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic send_good(input string name, input logic exp_locked);
    logic b;
    gen_bit(b);
    send(b, 1'b0);
    check({name, "_err"}, error_o, 1'b0);
    check({name, "_lock"}, locked_o, exp_locked);
    step();
  endtask

  task automatic send_bad(input string name, input logic exp_locked);
    logic b;
    gen_bit(b);
    send(~b, 1'b0);
    check({name, "_err"}, error_o, 1'b1);
    check({name, "_lock"}, locked_o, exp_locked);
    step();
  endtask

  initial begin
    logic b;
    // Lock-up on bits 0,0,1,0,1 from seed 00001, one valid every 3 cycles.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0};

    reset_i = 1'b1; load_taps_i = 1'b0; clear_i = 1'b0;
    bit_i = 1'b0; bit_valid_i = 1'b0; taps_i = 5'b0;
    step(); step();
    check("rst_locked", locked_o, 1'b0);
    check("rst_error", error_o, 1'b0);
    check("rst_count", err_count_o, 8'd0);
    reset_i = 1'b0;

    for (int i = 0; i < 15; i++) begin
      bit_i = tbl[i].b; bit_valid_i = tbl[i].valid;
      step();
      bit_valid_i = 1'b0;
      check($sformatf("tbl%0d_lock", i), locked_o, tbl[i].exp_locked);
      check($sformatf("tbl%0d_err", i), error_o, tbl[i].exp_err);
      check($sformatf("tbl%0d_cnt", i), err_count_o, tbl[i].exp_cnt);
    end

    // Generator has emitted 5 bits from 00001 and now sits at 00101.
    gen_taps = 5'b10100; gen_state = 5'b00101;
    for (int i = 0; i < 100; i++) send_good("run", 1'b1);
    check("run_count", err_count_o, 8'd0);

    // One flipped bit echoes through taps 2 and 4: pulses at offsets 0, 3, 5.
    send_bad("flip0", 1'b1);
    for (int j = 1; j <= 10; j++) begin
      gen_bit(b);
      send(b, 1'b0);
      check($sformatf("flip%0d_err", j), error_o, (j == 3 || j == 5));
      check($sformatf("flip%0d_lock", j), locked_o, 1'b1);
      step();
    end
    check("flip_count", err_count_o, 8'd3);
    clear_i = 1'b1; step(); clear_i = 1'b0;
    check("clear_count", err_count_o, 8'd0);

    // Three consecutive inverted bits drop lock; five good bits relock.
    send_bad("loss1", 1'b1);
    send_bad("loss2", 1'b1);
    send_bad("loss3", 1'b0);
    check("loss_count", err_count_o, 8'd3);
    for (int i = 0; i < 4; i++) send_good("relock_pre", 1'b0);
    send_good("relock", 1'b1);
    for (int i = 0; i < 5; i++) send_good("relock_run", 1'b1);

    // All-zero seed never locks and restarts the seed count.
    load_taps_i = 1'b1; taps_i = 5'b10100; step(); load_taps_i = 1'b0;
    check("zero_load_lock", locked_o, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 1'b0);
      check("zero_err", error_o, 1'b0);
      check("zero_lock", locked_o, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) send_good("zero_reseed", 1'b0);
    send_good("zero_relock", 1'b1);

    // Saturation: 87 rounds of 3 mispredicts + relock.
    clear_i = 1'b1; step(); clear_i = 1'b0;
    for (int r = 1; r <= 87; r++) begin
      for (int k = 0; k < 3; k++) begin gen_bit(b); send(~b, 1'b0); end
      for (int k = 0; k < 5; k++) begin gen_bit(b); send(b, 1'b0); end
      check($sformatf("sat_r%0d", r), err_count_o, (3 * r > 255) ? 255 : 3 * r);
    end
    check("sat_locked", locked_o, 1'b1);
    gen_bit(b); send(~b, 1'b1);
    check("clrwin_err", error_o, 1'b1);
    check("clrwin_cnt", err_count_o, 8'd0);
    gen_bit(b); send(~b, 1'b0);
    check("post_clr_cnt", err_count_o, 8'd1);
    check("post_clr_lock", locked_o, 1'b1);

    // Tap load discards a concurrent bit and keeps the error count.
    load_taps_i = 1'b1; taps_i = 5'b10010; bit_i = 1'b1; bit_valid_i = 1'b1;
    step();
    load_taps_i = 1'b0; bit_valid_i = 1'b0;
    check("load_lock", locked_o, 1'b0);
    check("load_err", error_o, 1'b0);
    check("load_cnt", err_count_o, 8'd1);
    gen_taps = 5'b10010; gen_state = 5'b00001;
    for (int i = 0; i < 4; i++) send_good("newtap_seed", 1'b0);
    send_good("newtap_lock", 1'b1);
    for (int i = 0; i < 10; i++) send_good("newtap_run", 1'b1);
    check("newtap_cnt", err_count_o, 8'd1);

    // Reset beats tap load and a concurrent mispredict.
    gen_bit(b);
    reset_i = 1'b1; load_taps_i = 1'b1; taps_i = 5'b10010;
    bit_i = ~b; bit_valid_i = 1'b1;
    step();
    reset_i = 1'b0; load_taps_i = 1'b0; bit_valid_i = 1'b0;
    check("rstpri_lock", locked_o, 1'b0);
    check("rstpri_err", error_o, 1'b0);
    check("rstpri_cnt", err_count_o, 8'd0);
    gen_taps = 5'b10100; gen_state = 5'b00001;
    for (int i = 0; i < 4; i++) send_good("deftap_seed", 1'b0);
    send_good("deftap_lock", 1'b1);
    for (int i = 0; i < 20; i++) send_good("deftap_run", 1'b1);
    check("deftap_cnt", err_count_o, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side companion to the on-chip LFSR generator. Takes the generator's serial output bit stream, self-synchronizes a local copy of the LFSR from the received bits, and predicts each following bit. It flags mismatches, counts errors, and reports lock status for display or debug. It sits between a serial input pin (or on-chip loopback) and the status/segment outputs.

Parameters:
BITS, 5, LFSR width and width of the taps_i port.
DEFAULT_TAPS, 5'b10100, tap mask loaded at reset (x^5+x^3+1, maximal length).
LOSS_THRESH, 3, number of consecutive mispredicted bits that drops lock.
COUNT_BITS, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_i  input  1  synchronous, active-high reset.
taps_i  input  BITS  new tap mask.
load_taps_i  input  1  latch taps_i and force resync.
clear_i  input  1  clear err_count_o only.
bit_i  input  1  received serial bit.
bit_valid_i  input  1  bit_i is valid this cycle (one bit per asserted cycle).
locked_o  output  1  checker is synchronized.
error_o  output  1  one-cycle pulse on a mispredicted bit.
err_count_o  output  COUNT_BITS  saturating mispredict count.

Behaviour:
- LFSR convention, identical to the generator: Fibonacci form. fb = ^(state & taps); next = {state[BITS-2:0], fb}; the transmitted bit is fb.
- Registers: taps_q, shift_q[BITS-1:0], seed_cnt, consec_err, state, err_count, error pulse.
- Reset: taps_q=DEFAULT_TAPS, shift_q=0, seed_cnt=0, consec_err=0, state=SEED, locked_o=0, error_o=0, err_count_o=0.
- SEED state, on bit_valid_i:
  - shift_q <= {shift_q[BITS-2:0], bit_i}; seed_cnt++.
  - On the BITS-th valid bit, go to LOCKED, unless the new shift_q is all-zero. In that case stay in SEED with seed_cnt=0, because all-zero is an illegal LFSR state.
  - No errors are reported in SEED.
- LOCKED state, on bit_valid_i:
  - pred = ^(shift_q & taps_q).
  - shift_q always shifts in the received bit_i, never the prediction (self-synchronizing).
  - bit_i==pred: consec_err <= 0.
  - bit_i!=pred: error_o=1 next cycle; err_count++ (saturates at all-ones, no wrap); consec_err++.
  - When consec_err reaches LOSS_THRESH: go to SEED, seed_cnt=0, consec_err=0, locked_o=0.
- Cycles with bit_valid_i low: no state change; error_o=0.
- Latency: locked_o and error_o are registered and change on the edge that consumes the qualifying bit, so they are visible the cycle after bit_valid_i.
- load_taps_i:
  - taps_q <= taps_i; state=SEED, seed_cnt=0, consec_err=0, error_o=0.
  - err_count is kept.
  - A bit_valid_i in the same cycle is discarded.
- clear_i: err_count <= 0. If a mispredict occurs in the same cycle, clear wins and the count is 0; error_o still pulses.
- Priority: reset_i > load_taps_i > clear_i > bit processing.
- taps_q=0 is legal. pred is then always 0, so an all-zero seed never locks.

Decomposition:
- Shared package: state enum {SEED, LOCKED}; DEFAULT_TAPS constant shared with the generator so both ends agree.
- One sub-module: sat_counter (parameterized width; inc, clear, clear-priority), reusable elsewhere.
- Prediction parity stays inline.

Test Plan:
- Lock: generator taps 5'b10100, seed 5'b00001 sends bits 0,0,1,0,1 with valid every 3 cycles. locked_o rises the cycle after the 5th valid with shift_q=5'b00101. Running 100 further correct bits gives error_o never high and err_count_o=0.
- Single error: when locked, flip one bit. error_o pulses once the next cycle and err_count_o=1. Because shift_q takes the received bit, the flipped bit also enters the next BITS predictions, so this can produce further mispredicts. Record the exact count against a reference model of the same convention. With LOSS_THRESH=3, locked_o must stay high.
- Loss of lock: when locked, feed 3 consecutive inverted bits. err_count_o=3 and locked_o falls the cycle after the 3rd bit. Then 5 correct bits relock.
- All-zero seed: feed five 0 bits. locked_o stays 0, seed_cnt returns to 0, and there are no error pulses.
- Saturation/clear: force 260 mispredicts (relocking as needed). err_count_o holds 255. Assert clear_i together with a mispredict: err_count_o=0 and error_o=1.
- Taps change/reset priority: load_taps_i=1 with taps_i=5'b10010 and a concurrent valid bit. The bit is ignored and the checker enters SEED. Assert reset_i together with load_taps_i: taps return to 5'b10100 and all outputs are 0.
